// File: rtl/zoomed_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// zoomed_fetch_ctrl
//
// Purpose:
//   Sits between the zoomed address generator and the DRAM read-command
//   stream. Pulls addresses from the generator (incr/addr/tlast), presents
//   them as a valid/ready command stream, limits outstanding reads with a
//   credit counter, and signals frame completion once every read of the
//   frame has returned.
//
// Ports:
//   clk_in          system clock
//   rst_in          synchronous active-high reset
//   enable_in       permits a frame to start
//   frame_start_in  single-cycle pulse requesting one frame fetch
//   gen_addr_in     current generator address (always valid)
//   gen_tlast_in    gen_addr_in is the last address of the frame
//   gen_incr_out    advance pulse to the generator
//   cmd_addr_out    DRAM read address
//   cmd_tlast_out   last command of the frame
//   cmd_valid_out   command valid
//   cmd_ready_in    command accepted
//   rsp_done_in     one read returned and consumed (returns one credit)
//   busy_out        high while a frame is running or draining
//   frame_done_out  single-cycle pulse at frame completion
//   beats_out       commands issued in the last completed frame
//   credit_err_out  sticky: a response arrived with nothing reserved
//
// Optional feature (macro ZOOM_FETCH_STATS_EN):
//   bp_stall_cycles_out      RUN cycles stalled by command backpressure
//   credit_stall_cycles_out  RUN cycles stalled by exhausted credits
// ---------------------------------------------------------------------------
module zoomed_fetch_ctrl #(
  parameter int MAX_OUTSTANDING = 64,
  parameter int BEAT_CNT_W      = 20
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  enable_in,
  input  logic                  frame_start_in,
  input  logic [26:0]           gen_addr_in,
  input  logic                  gen_tlast_in,
  output logic                  gen_incr_out,
  output logic [26:0]           cmd_addr_out,
  output logic                  cmd_tlast_out,
  output logic                  cmd_valid_out,
  input  logic                  cmd_ready_in,
  input  logic                  rsp_done_in,
  output logic                  busy_out,
  output logic                  frame_done_out,
  output logic [BEAT_CNT_W-1:0] beats_out,
  output logic                  credit_err_out
`ifdef ZOOM_FETCH_STATS_EN
  ,
  output logic [31:0]           bp_stall_cycles_out,
  output logic [31:0]           credit_stall_cycles_out
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [7:0] MAX_RES = 8'(MAX_OUTSTANDING);

  state_t                state_q, state_d;
  logic [7:0]            reserved_q;
  logic [BEAT_CNT_W-1:0] beat_cnt_q;
  logic [BEAT_CNT_W-1:0] beats_q;
  logic                  last_taken_q;
  logic                  cmd_valid_q;
  logic                  cmd_tlast_q;
  logic [26:0]           cmd_addr_q;
  logic                  credit_err_q;

  logic gen_incr;
  logic frame_done;
  logic start_go;
  logic cmd_fire;
  logic rsp_ok;

  assign start_go = frame_start_in && enable_in;
  assign cmd_fire = cmd_valid_q && cmd_ready_in;
  // A response with nothing reserved is an error and must not underflow.
  assign rsp_ok   = rsp_done_in && (reserved_q != 8'd0);

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. DRAIN always lasts at least one cycle because the
  // completion check looks at the registered reserved count.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_go) state_d = RUN;
      RUN:     if (cmd_fire && cmd_tlast_q) state_d = DRAIN;
      DRAIN:   if (reserved_q == 8'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic. The credit check uses the registered reserved count, so a
  // same-cycle return never enables a load.
  always_comb begin
    gen_incr   = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      RUN:     gen_incr = !last_taken_q && (reserved_q < MAX_RES) &&
                          (!cmd_valid_q || cmd_ready_in);
      DRAIN:   frame_done = (reserved_q == 8'd0);
      default: ;
    endcase
  end

  assign gen_incr_out   = gen_incr;
  assign frame_done_out = frame_done;
  assign busy_out       = (state_q != IDLE);
  assign cmd_addr_out   = cmd_addr_q;
  assign cmd_tlast_out  = cmd_tlast_q;
  assign cmd_valid_out  = cmd_valid_q;
  assign beats_out      = beats_q;
  assign credit_err_out = credit_err_q;

  // Command output register: a load may coincide with the handshake of the
  // previous command, giving one command per cycle at full throughput.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cmd_valid_q <= 1'b0;
      cmd_tlast_q <= 1'b0;
      cmd_addr_q  <= '0;
    end else if (gen_incr) begin
      cmd_valid_q <= 1'b1;
      cmd_tlast_q <= gen_tlast_in;
      cmd_addr_q  <= gen_addr_in;
    end else if (cmd_fire) begin
      cmd_valid_q <= 1'b0;
    end
  end

  // last_taken stops further generator pulls once the tlast address is in.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      last_taken_q <= 1'b0;
    end else if (state_q == IDLE && start_go) begin
      last_taken_q <= 1'b0;
    end else if (gen_incr && gen_tlast_in) begin
      last_taken_q <= 1'b1;
    end
  end

  // Reserved credit counter; a simultaneous reserve and return cancel out.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      reserved_q <= 8'd0;
    end else begin
      case ({gen_incr, rsp_ok})
        2'b10:   reserved_q <= reserved_q + 8'd1;
        2'b01:   reserved_q <= reserved_q - 8'd1;
        default: ;
      endcase
    end
  end

  // Per-frame beat counter (saturating) and the completed-frame snapshot.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      beat_cnt_q <= '0;
      beats_q    <= '0;
    end else begin
      if (state_q == IDLE && start_go) begin
        beat_cnt_q <= '0;
      end else if (cmd_fire && (beat_cnt_q != '1)) begin
        beat_cnt_q <= beat_cnt_q + 1'b1;
      end
      if (frame_done) begin
        beats_q <= beat_cnt_q;
      end
    end
  end

  // Sticky credit error, cleared only by reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      credit_err_q <= 1'b0;
    end else if (rsp_done_in && (reserved_q == 8'd0)) begin
      credit_err_q <= 1'b1;
    end
  end

`ifdef ZOOM_FETCH_STATS_EN
  logic [31:0] bp_stall_q;
  logic [31:0] credit_stall_q;

  // Stall statistics, saturating, restarted with every accepted frame start.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bp_stall_q     <= '0;
      credit_stall_q <= '0;
    end else if (state_q == IDLE && start_go) begin
      bp_stall_q     <= '0;
      credit_stall_q <= '0;
    end else if (state_q == RUN) begin
      if (cmd_valid_q && !cmd_ready_in && (bp_stall_q != '1)) begin
        bp_stall_q <= bp_stall_q + 32'd1;
      end
      if (!last_taken_q && (reserved_q == MAX_RES) && (credit_stall_q != '1)) begin
        credit_stall_q <= credit_stall_q + 32'd1;
      end
    end
  end

  assign bp_stall_cycles_out     = bp_stall_q;
  assign credit_stall_cycles_out = credit_stall_q;
`endif

endmodule
